// File: rtl/vip_stream_pkg.sv
// rtl/vip_stream_pkg.sv - shared VIP stream defaults, state encoding and pixel type
package vip_stream_pkg;

    localparam int VIP_DWIDTH = 24;
    localparam int VIP_DIMW   = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo_reader_if.sv
// rtl/pixel_fifo_reader_if.sv - FIFO read side and output pixel stream of the reader
interface pixel_fifo_reader_if
    import vip_stream_pkg::*;
#(
    parameter int DWIDTH = VIP_DWIDTH,
    parameter int DIMW   = VIP_DIMW
);

    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_q;
    logic              fifo_rdreq;

    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;
    logic [DIMW-1:0]   out_x;
    logic [DIMW-1:0]   out_y;
    logic [DIMW-1:0]   frame_cnt;

    modport master (
        input  fifo_empty, fifo_q, out_ready,
        output fifo_rdreq, out_valid, out_data, out_sof, out_eol, out_eof,
               out_x, out_y, frame_cnt
    );

    modport slave (
        output fifo_empty, fifo_q, out_ready,
        input  fifo_rdreq, out_valid, out_data, out_sof, out_eol, out_eof,
               out_x, out_y, frame_cnt
    );

endinterface

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - 4-entry register buffer absorbing the FIFO read latency
module pixel_skid_fifo #(
    parameter int DWIDTH = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic [2:0]        occ
);

    logic [DWIDTH-1:0] mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic              pop_ok;

    assign pop_ok = pop && (occ != 3'd0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fifo_reader.sv
// rtl/pixel_fifo_reader.sv - pops pixel FIFO words and re-frames them into a marked pixel stream
module pixel_fifo_reader
    import vip_stream_pkg::*;
#(
    parameter int DWIDTH = VIP_DWIDTH,
    parameter int DIMW   = VIP_DIMW
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [DIMW-1:0] width,
    input  logic [DIMW-1:0] height,
    input  logic [DIMW-1:0] num_frame,
    output logic            busy,
    output logic            done,
    pixel_fifo_reader_if.master px
);

    localparam int PW = 2 * DIMW;
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]        state;
    logic [DIMW-1:0]   width_q, height_q, nframe_q;
    logic [PW-1:0]     frame_px, req_px;
    logic [DIMW-1:0]   req_frame;
    logic              req_done, rd_pending;
    logic [DIMW-1:0]   x_q, y_q, f_q;
    logic [2:0]        occ;
    logic [3:0]        inflight;
    logic [DWIDTH-1:0] head;
    logic              pop, at_eol, at_eof, last_px;

    // Words already requested but not yet landed still need a free slot.
    assign inflight      = {1'b0, occ} + {3'b000, rd_pending};
    assign px.fifo_rdreq = (state == S_RUN) && !px.fifo_empty && !req_done && (inflight < 4'd4);

    assign px.out_valid = (occ != 3'd0);
    assign pop          = px.out_valid && px.out_ready;
    assign at_eol       = (x_q == width_q - 1'b1);
    assign at_eof       = at_eol && (y_q == height_q - 1'b1);
    assign last_px      = pop && at_eof && (f_q == nframe_q - 1'b1);

    assign px.out_data  = px.out_valid ? head : '0;
    assign px.out_sof   = px.out_valid && (x_q == '0) && (y_q == '0);
    assign px.out_eol   = px.out_valid && at_eol;
    assign px.out_eof   = px.out_valid && at_eof;
    assign px.out_x     = x_q;
    assign px.out_y     = y_q;
    assign px.frame_cnt = f_q;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    pixel_skid_fifo #(.DWIDTH(DWIDTH)) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rd_pending),
        .push_data (px.fifo_q),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            nframe_q   <= '0;
            frame_px   <= '0;
            req_px     <= '0;
            req_frame  <= '0;
            req_done   <= 1'b0;
            rd_pending <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            f_q        <= '0;
        end else begin
            rd_pending <= px.fifo_rdreq;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if ((width == '0) || (height == '0) || (num_frame == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_RUN;
                            width_q   <= width;
                            height_q  <= height;
                            nframe_q  <= num_frame;
                            frame_px  <= PW'(width) * PW'(height);
                            req_px    <= '0;
                            req_frame <= '0;
                            req_done  <= 1'b0;
                            x_q       <= '0;
                            y_q       <= '0;
                            f_q       <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (last_px) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (px.fifo_rdreq) begin
                if (req_px == frame_px - 1'b1) begin
                    req_px    <= '0;
                    req_frame <= req_frame + 1'b1;
                    if (req_frame == nframe_q - 1'b1) begin
                        req_done <= 1'b1;
                    end
                end else begin
                    req_px <= req_px + 1'b1;
                end
            end

            if (pop) begin
                if (at_eol) begin
                    x_q <= '0;
                    if (at_eof) begin
                        y_q <= '0;
                        f_q <= f_q + 1'b1;
                    end else begin
                        y_q <= y_q + 1'b1;
                    end
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_fifo_reader.sv
// tb/tb_pixel_fifo_reader.sv - self-checking bench for pixel_fifo_reader
module tb_pixel_fifo_reader;
    import vip_stream_pkg::*;

    localparam int DW = VIP_DWIDTH;
    localparam int DM = VIP_DIMW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DM-1:0] width = '0, height = '0, num_frame = '0;
    logic          busy, done;

    pixel_fifo_reader_if #(.DWIDTH(DW), .DIMW(DM)) pif ();

    pixel_fifo_reader #(.DWIDTH(DW), .DIMW(DM)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .width     (width),
        .height    (height),
        .num_frame (num_frame),
        .busy      (busy),
        .done      (done),
        .px        (pif.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof, eol, eof;
        logic [DM-1:0] x, y, f;
        int            cyc;
    } beat_t;

    beat_t         got[$];
    beat_t         cur, snap;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] words[$];
    logic [DW-1:0] next_q = '0;
    bit            next_v = 0, toggle_en = 0, ready_rand = 0, tog = 0, prev_stall = 0;
    int            checks = 0, failures = 0;
    int            cyc = 0, rd_cnt = 0, first_rd = -1, start_cyc = -1, busy_cyc = -1;
    int            done_cnt = 0, done_cyc = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // External FIFO model: inputs change only #1 after the rising edge.
    always @(posedge clock) begin
        #1;
        if (next_v) begin
            pif.fifo_q = next_q;
            next_v = 0;
        end
        tog = ~tog;
        pif.fifo_empty = (fq.size() == 0) || (toggle_en && tog);
        pif.out_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            check("occ_max", dut.u_skid.occ <= 3'd4, 1);
            if (pif.fifo_rdreq) begin
                check("rd_while_empty", pif.fifo_empty, 0);
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                if (fq.size() > 0) begin
                    next_q = fq.pop_front();
                    next_v = 1;
                end
            end
            if (start && start_cyc < 0) start_cyc = cyc;
            if (busy && busy_cyc < 0) busy_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            cur.data = pif.out_data;
            cur.sof  = pif.out_sof;
            cur.eol  = pif.out_eol;
            cur.eof  = pif.out_eof;
            cur.x    = pif.out_x;
            cur.y    = pif.out_y;
            cur.f    = pif.frame_cnt;
            cur.cyc  = cyc;
            if (prev_stall) begin
                check("stall_valid", pif.out_valid, 1);
                check("stall_data", cur.data, snap.data);
                check("stall_mark", {cur.sof, cur.eol, cur.eof}, {snap.sof, snap.eol, snap.eof});
                check("stall_xyf", {cur.x, cur.y, cur.f}, {snap.x, snap.y, snap.f});
            end
            if (pif.out_valid && pif.out_ready) got.push_back(cur);
            prev_stall = pif.out_valid && !pif.out_ready;
            snap = cur;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_rdreq"}, pif.fifo_rdreq, 0);
        check({tag, "_valid"}, pif.out_valid, 0);
        check({tag, "_data"}, pif.out_data, 0);
        check({tag, "_sof"}, pif.out_sof, 0);
        check({tag, "_eol"}, pif.out_eol, 0);
        check({tag, "_eof"}, pif.out_eof, 0);
        check({tag, "_x"}, pif.out_x, 0);
        check({tag, "_y"}, pif.out_y, 0);
        check({tag, "_frame"}, pif.frame_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic load(input int total, input bit fixed);
        pixel_t p;
        words.delete();
        got.delete();
        for (int i = 0; i < total + 2; i++) begin
            if (fixed) begin
                p.r = 8'(3 * i + 1);
                p.g = 8'(3 * i + 2);
                p.b = 8'(3 * i + 3);
            end else begin
                p = DW'($urandom);
            end
            words.push_back(p);
            fq.push_back(p);
        end
        rd_cnt = 0; first_rd = -1; start_cyc = -1; busy_cyc = -1;
        done_cnt = 0; done_cyc = -1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse(input int w, input int h, input int nf);
        width = DM'(w); height = DM'(h); num_frame = DM'(nf);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit interfere);
        int lim = 0;
        while (done_cnt == 0 && lim < 2000) begin
            @(posedge clock);
            #1;
            lim++;
            if (interfere && lim == 6) pulse(7, 1, 1);
        end
        check("done_timeout", done_cnt > 0, 1);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic verify(input int w, input int h, input int nf, input bit timing);
        int total = w * h * nf;
        int r;
        check("done_count", done_cnt, 1);
        check("beat_count", got.size(), total);
        check("read_count", rd_cnt, total);
        check("busy_latency", busy_cyc, (total > 0) ? start_cyc + 1 : -1);
        if (total == 0) check("done_latency", done_cyc, start_cyc + 1);
        else if (got.size() > 0) check("done_latency", done_cyc, got[got.size() - 1].cyc + 1);
        if (timing && total > 0) check("rd_latency", first_rd, start_cyc + 1);
        for (int i = 0; i < got.size() && i < total; i++) begin
            r = i % (w * h);
            check("pix_data", got[i].data, words[i]);
            check("pix_mark", {got[i].sof, got[i].eol, got[i].eof},
                  {(r == 0), (r % w == w - 1), (r == w * h - 1)});
            check("pix_xyf", {got[i].x, got[i].y, got[i].f},
                  {DM'(r % w), DM'(r / w), DM'(i / (w * h))});
            if (timing) check("pix_cycle", got[i].cyc, first_rd + 2 + i);
        end
    endtask

    task automatic run(input int w, input int h, input int nf, input bit fixed,
                       input bit rdy, input bit tgl, input bit timing, input bit interfere);
        ready_rand = rdy;
        toggle_en  = tgl;
        load(w * h * nf, fixed);
        pulse(w, h, nf);
        wait_done(interfere);
        verify(w, h, nf, timing);
        fq.delete();
        ready_rand = 0;
        toggle_en  = 0;
    endtask

    initial begin
        int lim;
        pif.fifo_empty = 1'b1;
        pif.fifo_q     = '0;
        pif.out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_checks("reset");
        reset_n = 1'b1;

        run(2, 2, 1, 1, 0, 0, 1, 0);
        run(3, 2, 3, 0, 0, 0, 1, 0);
        run(4, 4, 1, 0, 1, 0, 0, 1);
        run(4, 4, 1, 0, 0, 1, 0, 0);
        run(1, 3, 2, 0, 0, 0, 1, 0);
        run(3, 0, 1, 0, 0, 0, 0, 0);

        load(16, 0);
        pulse(4, 4, 1);
        lim = 0;
        while (got.size() < 5 && lim < 200) begin
            @(posedge clock);
            #1;
            lim++;
        end
        check("mid_reset_progress", got.size() >= 5, 1);
        reset_n = 1'b0;
        #1;
        reset_checks("mid_reset");
        fq.delete();
        next_v = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        run(4, 4, 1, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
